// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered immediate/shift-amount extender for the multi-cycle datapath.
// The main register drives the output; one skid register absorbs a beat of back-pressure.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHL   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  // state   | meaning
  // S_EMPTY | main and skid empty, output idle
  // S_MAIN  | main holds a result, skid empty
  // S_FULL  | main and skid both hold results, input stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             take;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_val;
  logic [OUT_W-1:0] skid_data;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // Size casts keep this legal when IN_W == OUT_W (no zero-width replication).
  assign ext_zero = OUT_W'(in_data);
  assign ext_sign = OUT_W'($signed(in_data));

  always_comb begin
    ext_val = ext_zero;
    unique case (in_mode)
      2'd0: ext_val = ext_zero;
      2'd1: ext_val = ext_sign;
      2'd2: ext_val = ext_zero << (OUT_W - IN_W);
      2'd3: ext_val = ext_sign << SHL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_nxt = S_MAIN;
        S_MAIN: begin
          if (take && !accept)      state_nxt = S_EMPTY;
          else if (!take && accept) state_nxt = S_FULL;
        end
        S_FULL:  if (take) state_nxt = S_MAIN;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // in_ready/out_valid decode only the registered state, never out_ready.
  always_comb begin
    in_ready       = (state != S_FULL);
    out_valid      = (state != S_EMPTY);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      load_main_in   = accept && ((state == S_EMPTY) || (state == S_MAIN && take));
      load_skid      = accept && (state == S_MAIN) && !take;
      load_main_skid = (state == S_FULL) && take;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_skid)    out_data <= skid_data;
      else if (load_main_in) out_data <= ext_val;
      if (load_skid) skid_data <= ext_val;
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Bench for ext_unit_pipe: a 16->32 and a 5->32 instance checked against
// a queue scoreboard, a vector table, and hand-built stall/flush/reset sequences.
module tb_ext_unit_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data;
  logic [1:0]  a_in_mode;
  logic [31:0] a_out_data;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [4:0]  b_in_data;
  logic [1:0]  b_in_mode;
  logic [31:0] b_out_data;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .SHL(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  ext_unit_pipe #(.IN_W(5), .OUT_W(32), .SHL(2)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] a_exp, b_exp, a_prev, b_prev;
  logic        a_hold, b_hold;

  typedef struct {
    bit          sel_b;
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m, input int w);
    logic [31:0] z, s;
    z = '0;
    for (int i = 0; i < w; i++) z[i] = d[i];
    s = z;
    if (d[w-1]) for (int i = w; i < 32; i++) s[i] = 1'b1;
    case (m)
      2'd0:    return z;
      2'd1:    return s;
      2'd2:    return z << (32 - w);
      default: return s << 2;
    endcase
  endfunction

  // One clock: compare at the negedge with inputs settled, update the model, advance.
  task automatic step();
    check("a_out_valid", {31'b0, a_out_valid}, {31'b0, qa.size() > 0});
    check("a_in_ready", {31'b0, a_in_ready}, {31'b0, qa.size() < 2});
    if (a_hold) check("a_hold_stable", a_out_data, a_prev);
    if (a_out_valid && a_out_ready && qa.size() > 0) check("a_data", a_out_data, qa.pop_front());
    if (a_flush) qa.delete();
    else if (a_in_valid && a_in_ready) qa.push_back(a_exp);
    a_hold = a_out_valid && !a_out_ready && !a_flush;
    a_prev = a_out_data;

    check("b_out_valid", {31'b0, b_out_valid}, {31'b0, qb.size() > 0});
    check("b_in_ready", {31'b0, b_in_ready}, {31'b0, qb.size() < 2});
    if (b_hold) check("b_hold_stable", b_out_data, b_prev);
    if (b_out_valid && b_out_ready && qb.size() > 0) check("b_data", b_out_data, qb.pop_front());
    if (b_flush) qb.delete();
    else if (b_in_valid && b_in_ready) qb.push_back(b_exp);
    b_hold = b_out_valid && !b_out_ready && !b_flush;
    b_prev = b_out_data;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
    a_in_valid = v;
    a_in_data  = d;
    a_in_mode  = m;
    a_exp      = e;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1; a_exp = '0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1; b_exp = '0;
    a_hold = 0; b_hold = 0; a_prev = '0; b_prev = '0;

    vecs[0]  = '{1'b0, 2'd0, 16'h8001, 32'h0000_8001};
    vecs[1]  = '{1'b0, 2'd1, 16'h8001, 32'hFFFF_8001};
    vecs[2]  = '{1'b0, 2'd2, 16'h1234, 32'h1234_0000};
    vecs[3]  = '{1'b0, 2'd3, 16'hFFFF, 32'hFFFF_FFFC};
    vecs[4]  = '{1'b0, 2'd1, 16'h7FFF, 32'h0000_7FFF};
    vecs[5]  = '{1'b0, 2'd3, 16'h4000, 32'h0001_0000};
    vecs[6]  = '{1'b0, 2'd3, 16'h8000, 32'hFFFE_0000};
    vecs[7]  = '{1'b0, 2'd0, 16'hFFFF, 32'h0000_FFFF};
    vecs[8]  = '{1'b0, 2'd2, 16'hFFFF, 32'hFFFF_0000};
    vecs[9]  = '{1'b1, 2'd0, 16'h001F, 32'h0000_001F};
    vecs[10] = '{1'b1, 2'd1, 16'h0010, 32'hFFFF_FFF0};
    vecs[11] = '{1'b1, 2'd2, 16'h0011, 32'h8800_0000};
    vecs[12] = '{1'b1, 2'd3, 16'h0010, 32'hFFFF_FFC0};
    vecs[13] = '{1'b1, 2'd1, 16'h000F, 32'h0000_000F};

    #1;
    check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("rst_out_data", a_out_data, 32'd0);
    check("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, streamed back to back with out_ready high.
    for (int i = 0; i < 14; i++) begin
      a_in_valid = 0;
      b_in_valid = 0;
      if (vecs[i].sel_b) begin
        b_in_valid = 1; b_in_data = vecs[i].data[4:0]; b_in_mode = vecs[i].mode; b_exp = vecs[i].exp;
      end else begin
        drive_a(1'b1, vecs[i].data, vecs[i].mode, vecs[i].exp);
      end
      step();
    end
    a_in_valid = 0; b_in_valid = 0;
    step(); step();
    check("table_drain_a", qa.size(), 0);
    check("table_drain_b", qb.size(), 0);

    // Back-pressure: A in main, B in skid, C refused.
    a_out_ready = 0;
    drive_a(1'b1, 16'd1, 2'd0, 32'd1); step();
    drive_a(1'b1, 16'd2, 2'd0, 32'd2); step();
    drive_a(1'b1, 16'd3, 2'd0, 32'd3);
    check("bp_in_ready_low", {31'b0, a_in_ready}, 32'd0);
    check("bp_main_holds_a", a_out_data, 32'd1);
    step();
    drive_a(1'b0, 16'd0, 2'd0, 32'd0);
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) step();
    check("bp_drained", {31'b0, a_out_valid}, 32'd0);

    // Flush with main+skid full and in_valid high.
    a_out_ready = 0;
    drive_a(1'b1, 16'h11, 2'd0, 32'h11); step();
    drive_a(1'b1, 16'h22, 2'd0, 32'h22); step();
    drive_a(1'b1, 16'h33, 2'd0, 32'h33); a_flush = 1; step();
    a_flush = 0;
    drive_a(1'b0, 16'h0, 2'd0, 32'h0);
    check("flush_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, a_in_ready}, 32'd1);
    // Flush while an input is being accepted: that input is discarded.
    drive_a(1'b1, 16'h55, 2'd0, 32'h55); step();
    drive_a(1'b1, 16'h66, 2'd0, 32'h66); a_flush = 1; step();
    a_flush = 0;
    a_out_ready = 1;
    drive_a(1'b1, 16'h44, 2'd0, 32'h44); step();
    drive_a(1'b0, 16'h0, 2'd0, 32'h0);
    check("post_flush_data", a_out_data, 32'h44);
    step();

    // Asynchronous reset between edges with both entries occupied.
    a_out_ready = 0;
    drive_a(1'b1, 16'h77, 2'd1, 32'h77); step();
    drive_a(1'b1, 16'h88, 2'd1, 32'h88); step();
    drive_a(1'b0, 16'h0, 2'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, a_out_valid}, 32'd0);
    check("arst_out_data", a_out_data, 32'd0);
    check("arst_in_ready", {31'b0, a_in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    qa.delete(); qb.delete(); a_hold = 0; b_hold = 0;
    a_out_ready = 1;
    drive_a(1'b1, 16'h0005, 2'd0, 32'h5); step();
    drive_a(1'b0, 16'h0, 2'd0, 32'h0);
    check("arst_first_data", a_out_data, 32'h5);
    step();

    // Random valid/ready stream on the 5-bit instance.
    for (int c = 0; c < 10000; c++) begin
      b_in_valid  = ($urandom_range(3) != 0);
      b_out_ready = ($urandom_range(9) < 7);
      b_in_data   = 5'($urandom);
      b_in_mode   = 2'($urandom);
      b_exp       = ref_ext({11'b0, b_in_data}, b_in_mode, 5);
      step();
    end
    b_in_valid = 0; b_out_ready = 1;
    step(); step(); step();
    check("rand_drain_b", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
